counter_updn_mod: RTL and testbench

Parametrised modulo up/down counter; next generation of the basic up/down counter used in the design.
- Adds a programmable modulus, synchronous load, wrap/saturate mode, a terminal-count flag and a wrap pulse.
- Sits beside timers and prescalers; `tc` and `wrap` feed downstream enables and interrupt logic.

---
 rtl/counter_updn_mod.sv | 116 +++++++++++
 tb/tb_counter_updn_mod.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_updn_mod.sv
// counter_updn_mod: modulo up/down counter with programmable modulus,
// synchronous load (clamped to the modulus), wrap/saturate mode, a
// combinational terminal-count flag and a registered wrap pulse.
// Optional feature macro: COUNTER_UPDN_WRAPCNT_EN adds the saturating
// wrap-event counter output wrap_cnt (WRAP_W bits).
module counter_updn_mod #(
    parameter int WIDTH  = 6,
    parameter int WRAP_W = 8
) (
    input  logic              clk50m,
    input  logic              rst,
    input  logic              en,
    input  logic              down,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  mod_val,
    input  logic              sat,
    output logic [WIDTH-1:0]  cnt,
    output logic              tc,
    output logic              wrap
`ifdef COUNTER_UPDN_WRAPCNT_EN
    ,
    output logic [WRAP_W-1:0] wrap_cnt
`endif
);

    // Reject parameter values outside the supported range at elaboration.
    if (WIDTH < 2 || WIDTH > 32 || WRAP_W < 1) begin : g_param_check
        $error("counter_updn_mod: WIDTH must be 2..32 and WRAP_W >= 1");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;

    // Next count and wrap pulse: load beats enable, enable beats hold.
    // All comparisons are WIDTH-bit unsigned, so mod_val = all-ones gives
    // plain binary wrap with no carry out.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = (load_val > mod_val) ? mod_val : load_val;
        end else if (en) begin
            if (!down) begin
                if (cnt_q < mod_val) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end else begin
                    // At or above the bound (the latter after mod_val was lowered).
                    cnt_d  = sat ? mod_val : '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (cnt_q > mod_val) begin
                    // Modulus lowered under the count: snap to the bound, no event.
                    cnt_d = mod_val;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - WIDTH'(1);
                end else begin
                    cnt_d  = sat ? '0 : mod_val;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    // Count and wrap-pulse registers.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    // Terminal count: the enabled step about to be taken will hit the boundary.
    always_comb begin
        tc = 1'b0;
        if (en && !load) begin
            tc = down ? (cnt_q == '0) : (cnt_q >= mod_val);
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;

`ifdef COUNTER_UPDN_WRAPCNT_EN
    logic [WRAP_W-1:0] wrap_cnt_q;
    logic [WRAP_W-1:0] wrap_cnt_d;

    // Wrap-event count: cleared by load, bumps on each wrap event, sticks at max.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (load) begin
            wrap_cnt_d = '0;
        end else if (wrap_d && (wrap_cnt_q != {WRAP_W{1'b1}})) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
        end
    end

    // Wrap-event count register.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_counter_updn_mod.sv
// Self-checking bench for counter_updn_mod (WIDTH=6, WRAP_W=8).
// Directed scenarios plus randomized traffic checked against an
// arithmetic reference model of the counting rules.
module tb_counter_updn_mod;

    localparam int WIDTH  = 6;
    localparam int WRAP_W = 8;
    localparam int WCNT_MAX = (1 << WRAP_W) - 1;

    logic              clk50m = 1'b0;
    logic              rst    = 1'b1;
    logic              en     = 1'b0;
    logic              down   = 1'b0;
    logic              load   = 1'b0;
    logic              sat    = 1'b0;
    logic [WIDTH-1:0]  load_val = '0;
    logic [WIDTH-1:0]  mod_val  = '0;
    logic [WIDTH-1:0]  cnt;
    logic              tc;
    logic              wrap;
`ifdef COUNTER_UPDN_WRAPCNT_EN
    logic [WRAP_W-1:0] wrap_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_cnt  = 0;
    bit m_wrap = 1'b0;
    int m_wcnt = 0;

    counter_updn_mod #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
        .clk50m   (clk50m),
        .rst      (rst),
        .en       (en),
        .down     (down),
        .load     (load),
        .load_val (load_val),
        .mod_val  (mod_val),
        .sat      (sat),
        .cnt      (cnt),
        .tc       (tc),
        .wrap     (wrap)
`ifdef COUNTER_UPDN_WRAPCNT_EN
        ,
        .wrap_cnt (wrap_cnt)
`endif
    );

    always #10 clk50m = ~clk50m;

    // Reference model: range is 0..mv, so wrap mode is arithmetic modulo mv+1.
    task automatic model_edge(input bit l, input bit e, input bit d, input bit s,
                              input int lv, input int mv);
        int nxt;
        bit w;
        nxt = m_cnt;
        w   = 1'b0;
        if (l) begin
            nxt = (lv < mv) ? lv : mv;
            m_wcnt = 0;
        end else if (e) begin
            if (m_cnt > mv) begin
                nxt = d ? mv : (s ? mv : 0);
                w   = !d;
            end else if (!s) begin
                nxt = d ? ((m_cnt + mv) % (mv + 1)) : ((m_cnt + 1) % (mv + 1));
                w   = d ? (m_cnt == 0) : (m_cnt == mv);
            end else begin
                nxt = d ? ((m_cnt > 0) ? m_cnt - 1 : 0) : ((m_cnt < mv) ? m_cnt + 1 : mv);
                w   = d ? (m_cnt == 0) : (m_cnt == mv);
            end
        end
        m_cnt  = nxt;
        m_wrap = w;
        if (w && m_wcnt < WCNT_MAX) m_wcnt = m_wcnt + 1;
    endtask

    // Drive one clock with the given inputs; report observed/expected tc before the edge.
    task automatic step(input bit l, input bit e, input bit d, input bit s,
                        input int lv, input int mv, output bit tc_obs, output bit tc_exp);
        load = l; en = e; down = d; sat = s;
        load_val = WIDTH'(lv); mod_val = WIDTH'(mv);
        #1;
        tc_obs = tc;
        tc_exp = e && !l && (d ? (m_cnt == 0) : (m_cnt >= mv));
        @(posedge clk50m);
        model_edge(l, e, d, s, lv, mv);
        @(negedge clk50m);
    endtask

    task automatic test_reset;
        bit to, te;
        @(posedge clk50m);
        @(negedge clk50m);
        n_checks++;
        if (cnt !== 6'd0 || wrap !== 1'b0)
            $display("FAIL reset_state: cnt=%0d wrap=%0b required cnt=0 wrap=0", cnt, wrap);
        else n_pass++;
        rst = 1'b0;
        // climb to 17 in saturate mode with mod_val=17 so wrap is high at 17
        step(1, 0, 0, 1, 0, 17, to, te);
        for (int i = 0; i < 18; i++) step(0, 1, 0, 1, 0, 17, to, te);
        n_checks++;
        if (cnt !== 6'd17 || wrap !== 1'b1)
            $display("FAIL reset_precount: cnt=%0d wrap=%0b required cnt=17 wrap=1", cnt, wrap);
        else n_pass++;
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (cnt !== 6'd0 || wrap !== 1'b0)
            $display("FAIL reset_async: cnt=%0d wrap=%0b required cnt=0 wrap=0 before edge", cnt, wrap);
        else n_pass++;
`ifdef COUNTER_UPDN_WRAPCNT_EN
        n_checks++;
        if (wrap_cnt !== 8'd0)
            $display("FAIL reset_wrap_cnt: wrap_cnt=%0d required 0", wrap_cnt);
        else n_pass++;
`endif
        m_cnt = 0; m_wrap = 1'b0; m_wcnt = 0;
        @(negedge clk50m);
        rst = 1'b0;
        $display("test_reset done: cnt=%0d wrap=%0b", cnt, wrap);
    endtask

    task automatic test_up_wrap;
        bit to, te;
        int wraps = 0;
        step(1, 0, 0, 0, 0, 9, to, te);
        for (int k = 0; k < 25; k++) begin
            n_checks++;
            if (cnt !== WIDTH'(k % 10))
                $display("FAIL up_wrap_cnt[%0d]: cnt=%0d required %0d", k, cnt, k % 10);
            else n_pass++;
            step(0, 1, 0, 0, 0, 9, to, te);
            n_checks++;
            if (to !== (k % 10 == 9))
                $display("FAIL up_wrap_tc[%0d]: tc=%0b required %0b", k, to, (k % 10 == 9));
            else n_pass++;
            if (wrap === 1'b1) wraps++;
        end
        n_checks++;
        if (wraps != 2)
            $display("FAIL up_wrap_pulses: wraps=%0d required 2", wraps);
        else n_pass++;
`ifdef COUNTER_UPDN_WRAPCNT_EN
        n_checks++;
        if (wrap_cnt !== 8'd2)
            $display("FAIL up_wrap_wrap_cnt: wrap_cnt=%0d required 2", wrap_cnt);
        else n_pass++;
`endif
        $display("test_up_wrap done: cnt=%0d wraps=%0d", cnt, wraps);
    endtask

    task automatic test_down_sat;
        bit to, te;
        int exp_c [6] = '{3, 2, 1, 0, 0, 0};
        bit exp_w [6] = '{0, 0, 0, 0, 1, 1};
        for (int k = 0; k < 6; k++) begin
            step(k == 0, 1, 1, 1, 3, 20, to, te);
            n_checks++;
            if (cnt !== WIDTH'(exp_c[k]) || wrap !== exp_w[k])
                $display("FAIL down_sat[%0d]: cnt=%0d wrap=%0b required cnt=%0d wrap=%0b",
                         k, cnt, wrap, exp_c[k], exp_w[k]);
            else n_pass++;
        end
        $display("test_down_sat done: cnt=%0d wrap=%0b", cnt, wrap);
    endtask

    task automatic test_load_clamp;
        bit to, te;
        step(1, 0, 0, 1, 30, 30, to, te);
        step(0, 1, 0, 1, 0, 30, to, te);   // saturating hit: wrap high
        n_checks++;
        if (cnt !== 6'd30 || wrap !== 1'b1)
            $display("FAIL load_pre: cnt=%0d wrap=%0b required cnt=30 wrap=1", cnt, wrap);
        else n_pass++;
        step(1, 1, 0, 0, 50, 30, to, te);  // a taken step would give 0
        n_checks++;
        if (to !== 1'b0)
            $display("FAIL load_tc: tc=%0b required 0 while load high", to);
        else n_pass++;
        n_checks++;
        if (cnt !== 6'd30 || wrap !== 1'b0)
            $display("FAIL load_clamp: cnt=%0d wrap=%0b required cnt=30 wrap=0", cnt, wrap);
        else n_pass++;
`ifdef COUNTER_UPDN_WRAPCNT_EN
        n_checks++;
        if (wrap_cnt !== 8'd0)
            $display("FAIL load_wrap_cnt: wrap_cnt=%0d required 0", wrap_cnt);
        else n_pass++;
`endif
        $display("test_load_clamp done: cnt=%0d wrap=%0b", cnt, wrap);
    endtask

    task automatic test_mod_lowered;
        bit to, te;
        step(1, 0, 0, 0, 0, 63, to, te);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0, 63, to, te);
        n_checks++;
        if (cnt !== 6'd40)
            $display("FAIL modlow_reach: cnt=%0d required 40", cnt);
        else n_pass++;
        step(0, 1, 0, 0, 0, 10, to, te);
        n_checks++;
        if (cnt !== 6'd0 || wrap !== 1'b1)
            $display("FAIL modlow_up: cnt=%0d wrap=%0b required cnt=0 wrap=1", cnt, wrap);
        else n_pass++;
        step(1, 0, 0, 0, 40, 63, to, te);
        step(0, 1, 1, 0, 0, 10, to, te);
        n_checks++;
        if (to !== 1'b0)
            $display("FAIL modlow_down_tc: tc=%0b required 0", to);
        else n_pass++;
        n_checks++;
        if (cnt !== 6'd10 || wrap !== 1'b0)
            $display("FAIL modlow_down: cnt=%0d wrap=%0b required cnt=10 wrap=0", cnt, wrap);
        else n_pass++;
        $display("test_mod_lowered done: cnt=%0d wrap=%0b", cnt, wrap);
    endtask

    task automatic test_full_range;
        bit to, te;
        int wraps = 0;
        step(1, 0, 0, 0, 0, 63, to, te);
        for (int i = 0; i < 200; i++) begin
            step(0, 1, 0, 0, 0, 63, to, te);
            if (wrap === 1'b1) wraps++;
        end
        n_checks++;
        if (cnt !== 6'd8 || wraps != 3)
            $display("FAIL full_up: cnt=%0d wraps=%0d required cnt=8 wraps=3", cnt, wraps);
        else n_pass++;
        wraps = 0;
        for (int i = 0; i < 200; i++) begin
            step(0, 1, 1, 0, 0, 63, to, te);
            if (wrap === 1'b1) wraps++;
        end
        n_checks++;
        if (cnt !== 6'd0 || wraps != 3)
            $display("FAIL full_down: cnt=%0d wraps=%0d required cnt=0 wraps=3", cnt, wraps);
        else n_pass++;
        $display("test_full_range done: cnt=%0d", cnt);
    endtask

    task automatic test_mod_zero;
        bit to, te;
        int wraps = 0;
        step(1, 0, 0, 0, 5, 0, to, te);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, i[0], i[1], 0, 0, to, te);
            if (wrap === 1'b1 && cnt === 6'd0) wraps++;
        end
        n_checks++;
        if (wraps != 8)
            $display("FAIL mod_zero: pulses_at_zero=%0d required 8", wraps);
        else n_pass++;
        $display("test_mod_zero done: pulses=%0d", wraps);
    endtask

    task automatic test_random;
        bit to, te, l, e, d, s;
        int lv, mv;
        int errs = 0;
        mv = 20;
        for (int i = 0; i < 400; i++) begin
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = ($urandom_range(0, 1) == 1);
            s  = ($urandom_range(0, 2) == 0);
            lv = $urandom_range(0, 63);
            if ($urandom_range(0, 15) == 0) mv = $urandom_range(0, 63);
            if ($urandom_range(0, 50) == 0) mv = 63;
            step(l, e, d, s, lv, mv, to, te);
            n_checks++;
            if (to !== te || cnt !== WIDTH'(m_cnt) || wrap !== m_wrap) begin
                $display("FAIL random[%0d]: tc=%0b cnt=%0d wrap=%0b required tc=%0b cnt=%0d wrap=%0b",
                         i, to, cnt, wrap, te, m_cnt, m_wrap);
                errs++;
            end else n_pass++;
`ifdef COUNTER_UPDN_WRAPCNT_EN
            n_checks++;
            if (wrap_cnt !== WRAP_W'(m_wcnt))
                $display("FAIL random_wrap_cnt[%0d]: wrap_cnt=%0d required %0d", i, wrap_cnt, m_wcnt);
            else n_pass++;
`endif
        end
        $display("test_random done: 400 cycles, %0d mismatching", errs);
    endtask

`ifdef COUNTER_UPDN_WRAPCNT_EN
    task automatic test_wrap_cnt_sat;
        bit to, te;
        step(1, 0, 0, 0, 0, 0, to, te);
        for (int i = 0; i < 270; i++) step(0, 1, 0, 0, 0, 0, to, te);
        n_checks++;
        if (wrap_cnt !== 8'd255)
            $display("FAIL wrap_cnt_sat: wrap_cnt=%0d required 255", wrap_cnt);
        else n_pass++;
        $display("test_wrap_cnt_sat done: wrap_cnt=%0d", wrap_cnt);
    endtask
`endif

    initial begin
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_load_clamp();
        test_mod_lowered();
        test_full_range();
        test_mod_zero();
`ifdef COUNTER_UPDN_WRAPCNT_EN
        test_wrap_cnt_sat();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
